// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the bit-counter width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH, hence WIDTH+1 distinct values.
    function automatic int unsigned cnt_width(input int unsigned width);
        return int'($clog2(width + 1));
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

    modport master (
        output start, sub, x, y, cin,
        input  busy, done, s, c, ovf
    );

    modport slave (
        input  start, sub, x, y, cin,
        output busy, done, s, c, ovf
    );

endinterface

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder cell: the only arithmetic element of the serial adder.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic c,
    output logic s
);

    assign s = x ^ y ^ cin;
    assign c = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock through a single
// full-adder cell, carry kept in a flop, start/busy/done handshake.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT = (WIDTH > 1) ? CNT_W'(WIDTH - 2) : '0;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cmsb;
    logic             fa_c;
    logic             fa_s;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             ovf_q;

    fa_bit u_fa (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .cin (carry),
        .c   (fa_c),
        .s   (fa_s)
    );

    // Shift the new sum bit in at the MSB; written as a shift of the
    // concatenation so it also holds for WIDTH == 1.
    assign r_next = WIDTH'({fa_s, r_sh} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cmsb   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            s_q    <= '0;
            c_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.x;
                        b_sh   <= bus.sub ? ~bus.y : bus.y;
                        carry  <= bus.sub ^ bus.cin;
                        // Covers WIDTH == 1, where the first bit is the MSB.
                        cmsb   <= bus.sub ^ bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    carry <= fa_c;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    cnt   <= cnt + 1'b1;
                    // Carry leaving bit WIDTH-2 is the carry into the MSB.
                    if ((WIDTH > 1) && (cnt == PENULT)) begin
                        cmsb <= fa_c;
                    end
                    if (cnt == LAST) begin
                        s_q    <= r_next;
                        c_q    <= fa_c;
                        ovf_q  <= cmsb ^ fa_c;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.c    = c_q;
    assign bus.ovf  = ovf_q;

endmodule
